chu_spi_slave: RTL and testbench

CHU_SPI_SLAVE -- requirements
Module: chu_spi_slave

---
 rtl/chu_spi_slave.sv | 197 +++++++++++++++++++
 tb/tb_chu_spi_slave.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chu_spi_slave.sv
// chu_spi_slave: register-mapped SPI slave with a byte RX buffer and TX hold.
// Define CHU_SPI_SLV_RXFIFO_EN for a 4-entry RX FIFO instead of one register.
module chu_spi_slave (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  output logic [31:0] rd_data,
  input  logic [31:0] wr_data,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_ss_n,
  output logic        spi_miso
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     state_q;
  logic [1:0] sclk_q, mosi_q, ss_q;
  logic       sclk_dly_q;
  logic [7:0] rx_shift_q, tx_shift_q, tx_hold_q;
  logic [2:0] bit_cnt_q;
  logic       tx_pend_q, cpol_q, cpha_q, ovr_q, miso_q;

  logic       sclk_s, mosi_s, ss_s;
  logic       rise, fall, smp_edge, sft_edge;
  logic       wr_tx, wr_stat, wr_mode;
  logic       pop, push, full, load, ovr_set;
  logic       rx_valid;
  logic [7:0] rx_data, rx_byte, load_byte;
  logic [2:0] rx_cnt;
  logic       unused_wr;

  assign unused_wr = ^wr_data[31:8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q     <= 2'b00;
      mosi_q     <= 2'b00;
      ss_q       <= 2'b11;
      sclk_dly_q <= 1'b0;
    end else begin
      sclk_q     <= {sclk_q[0], spi_sclk};
      mosi_q     <= {mosi_q[0], spi_mosi};
      ss_q       <= {ss_q[0], spi_ss_n};
      sclk_dly_q <= sclk_q[1];
    end
  end

  assign sclk_s   = sclk_q[1];
  assign mosi_s   = mosi_q[1];
  assign ss_s     = ss_q[1];
  assign rise     = sclk_s & ~sclk_dly_q;
  assign fall     = ~sclk_s & sclk_dly_q;
  assign smp_edge = (cpol_q ^ cpha_q) ? fall : rise;
  assign sft_edge = (cpol_q ^ cpha_q) ? rise : fall;

  assign wr_tx   = cs & write & (addr == 5'd1);
  assign wr_stat = cs & write & (addr == 5'd2);
  assign wr_mode = cs & write & (addr == 5'd3);
  assign pop     = cs & read & (addr == 5'd0) & rx_valid;

  assign push = (state_q == SHIFT) && !ss_s && smp_edge
             && (bit_cnt_q == 3'd7);
  assign load = ((state_q == IDLE) && !ss_s) || push;
  assign load_byte = tx_pend_q ? tx_hold_q : 8'hFF;
  assign rx_byte   = {rx_shift_q[6:0], mosi_s};
  assign ovr_set   = push && full && !pop;

`ifdef CHU_SPI_SLV_RXFIFO_EN
  logic [7:0] mem_q [4];
  logic [1:0] wp_q, rp_q;
  logic [2:0] cnt_q;
  logic       do_push;

  assign full    = (cnt_q == 3'd4);
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= rx_byte;
        wp_q        <= wp_q + 2'd1;
      end
      if (pop) rp_q <= rp_q + 2'd1;
      cnt_q <= cnt_q + {2'b0, do_push} - {2'b0, pop};
    end
  end

  assign rx_valid = (cnt_q != 3'd0);
  assign rx_data  = mem_q[rp_q];
  assign rx_cnt   = cnt_q;
`else
  logic       rx_valid_q;
  logic [7:0] rx_data_q;

  assign full = rx_valid_q;

  // A pop in the same cycle frees the slot for the incoming byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else if (push && (!rx_valid_q || pop)) begin
      rx_valid_q <= 1'b1;
      rx_data_q  <= rx_byte;
    end else if (pop) begin
      rx_valid_q <= 1'b0;
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign rx_cnt   = {2'b0, rx_valid_q};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      tx_hold_q  <= '0;
      bit_cnt_q  <= '0;
      tx_pend_q  <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      ovr_q      <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      if (wr_tx) tx_hold_q <= wr_data[7:0];
      if (wr_tx) tx_pend_q <= 1'b1;
      else if (load) tx_pend_q <= 1'b0;
      if (wr_mode && state_q == IDLE) begin
        cpol_q <= wr_data[0];
        cpha_q <= wr_data[1];
      end
      if (ovr_set) ovr_q <= 1'b1;
      else if (wr_stat && wr_data[2]) ovr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          miso_q    <= 1'b0;
          bit_cnt_q <= '0;
          if (!ss_s) begin
            state_q    <= SHIFT;
            tx_shift_q <= load_byte;
            miso_q     <= !cpha_q && load_byte[7];
          end
        end
        SHIFT: begin
          if (ss_s) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            miso_q     <= 1'b0;
          end else if (smp_edge) begin
            rx_shift_q <= rx_byte;
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            if (push) begin
              tx_shift_q <= load_byte;
              if (!cpha_q) miso_q <= load_byte[7];
            end
          end else if (sft_edge) begin
            // cpha=0 already shows bit 7; skip the edge right after a load
            if (cpha_q) begin
              miso_q     <= tx_shift_q[7];
              tx_shift_q <= {tx_shift_q[6:0], 1'b0};
            end else if (bit_cnt_q != 3'd0) begin
              miso_q     <= tx_shift_q[6];
              tx_shift_q <= {tx_shift_q[6:0], 1'b0};
            end
          end
        end
      endcase
    end
  end

  assign spi_miso = miso_q;

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      addr == 5'd0: rd_data = {23'b0, rx_valid, rx_data};
      addr == 5'd2: rd_data = {25'b0, rx_cnt, state_q == SHIFT,
                               ovr_q, !tx_pend_q, rx_valid};
      addr == 5'd3: rd_data = {30'b0, cpha_q, cpol_q};
      default:      rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_chu_spi_slave.sv
// tb_chu_spi_slave: directed bench for chu_spi_slave with an SPI master model.
// Build with CHU_SPI_SLV_RXFIFO_EN defined to exercise the FIFO variant.
module tb_chu_spi_slave;

  localparam int H = 8;

  logic        clk = 1'b0;
  logic        reset, cs, read, write;
  logic [4:0]  addr;
  logic [31:0] rd_data, wr_data;
  logic        spi_sclk, spi_mosi, spi_ss_n, spi_miso;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] sb[$];
  logic [7:0]  miso_sb[$];
  logic        cpol_m, cpha_m;

  always #5 clk = ~clk;

  chu_spi_slave dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .read     (read),
    .write    (write),
    .addr     (addr),
    .rd_data  (rd_data),
    .wr_data  (wr_data),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_ss_n (spi_ss_n),
    .spi_miso (spi_miso)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
    cs = 1'b1; read = 1'b1; addr = a;
    #1 d = rd_data;
    @(negedge clk);
    cs = 1'b0; read = 1'b0;
  endtask

  task automatic sb_check(input string tag);
    logic [31:0] d, e;
    e = 'x;
    if (sb.size() != 0) e = sb.pop_front();
    bus_rd(5'd0, d);
    check(tag, d, e);
  endtask

  // SPI master: pop_sync issues an addr0 read landing on the 8th sample edge
  task automatic xfer(input logic [7:0] tx, input int nbits,
                      input bit pop_sync, output logic [7:0] rx,
                      output logic [31:0] popped);
    logic [7:0] sh;
    sh = tx; rx = '0; popped = '0;
    spi_sclk = cpol_m; spi_ss_n = 1'b0;
    if (!cpha_m) spi_mosi = sh[7];
    repeat (H) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (!cpha_m) begin
        rx = {rx[6:0], spi_miso};
        spi_sclk = ~cpol_m;
        if (pop_sync && i == 7) begin
          repeat (2) @(negedge clk);
          cs = 1'b1; read = 1'b1; addr = 5'd0;
          #1 popped = rd_data;
          @(negedge clk);
          cs = 1'b0; read = 1'b0;
          repeat (H - 3) @(negedge clk);
        end else begin
          repeat (H) @(negedge clk);
        end
        spi_sclk = cpol_m;
        sh = {sh[6:0], 1'b0};
        spi_mosi = sh[7];
        repeat (H) @(negedge clk);
      end else begin
        spi_sclk = ~cpol_m;
        spi_mosi = sh[7];
        sh = {sh[6:0], 1'b0};
        repeat (H) @(negedge clk);
        rx = {rx[6:0], spi_miso};
        spi_sclk = cpol_m;
        repeat (H) @(negedge clk);
      end
    end
    spi_ss_n = 1'b1; spi_mosi = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] tx, input logic [7:0] exp,
                      input string tag);
    logic [7:0]  r, e;
    logic [31:0] p;
    miso_sb.push_back(exp);
    xfer(tx, 8, 1'b0, r, p);
    e = miso_sb.pop_front();
    check(tag, {24'b0, r}, {24'b0, e});
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, p;
    logic [7:0]  r, b;
    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0;
    addr = '0; wr_data = '0;
    spi_sclk = 1'b0; spi_mosi = 1'b0; spi_ss_n = 1'b1;
    cpol_m = 1'b0; cpha_m = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_miso", {31'b0, spi_miso}, 32'h0);
    bus_rd(5'd2, d); check("rst_stat", d, 32'h2);
    bus_rd(5'd3, d); check("rst_mode", d, 32'h0);
    bus_rd(5'd0, d); check("rst_rx", d, 32'h0);

    // mode 0 with a pending TX byte
    bus_wr(5'd1, 32'hA5);
    bus_rd(5'd2, d); check("pend_stat", d, 32'h0);
    sb.push_back(32'h13C);
    send(8'h3C, 8'hA5, "m0_miso");
    check("idle_miso", {31'b0, spi_miso}, 32'h0);
    sb_check("m0_rx");
    bus_rd(5'd2, d); check("m0_popped", d, 32'h2);

    // mode 3, nothing pending
    bus_wr(5'd3, 32'h3);
    bus_rd(5'd3, d); check("m3_mode", d, 32'h3);
    cpol_m = 1'b1; cpha_m = 1'b1; spi_sclk = 1'b1;
    repeat (4) @(negedge clk);
    sb.push_back(32'h181);
    send(8'h81, 8'hFF, "m3_miso");
    sb_check("m3_rx");

    bus_wr(5'd3, 32'h0);
    cpol_m = 1'b0; cpha_m = 1'b0; spi_sclk = 1'b0;
    repeat (4) @(negedge clk);

    // two bytes without a pop
`ifdef CHU_SPI_SLV_RXFIFO_EN
    sb.push_back(32'h111);
    sb.push_back(32'h122);
    send(8'h11, 8'hFF, "two_a_miso");
    send(8'h22, 8'hFF, "two_b_miso");
    bus_rd(5'd2, d); check("two_stat", d, 32'h23);
    sb_check("two_rx_a");
    sb_check("two_rx_b");
    bus_rd(5'd2, d); check("two_drained", d, 32'h2);
`else
    sb.push_back(32'h111);
    send(8'h11, 8'hFF, "two_a_miso");
    send(8'h22, 8'hFF, "two_b_miso");
    bus_rd(5'd2, d); check("ovr_stat", d, 32'h17);
    sb_check("ovr_rx");
    bus_rd(5'd2, d); check("ovr_sticky", d, 32'h6);
    bus_wr(5'd2, 32'h4);
    bus_rd(5'd2, d); check("ovr_clr", d, 32'h2);
`endif

    // ss_n rises after 5 bits
    xfer(8'hF0, 5, 1'b0, r, p);
    bus_rd(5'd2, d); check("abort_stat", d, 32'h2);
    check("abort_cnt", {29'b0, dut.bit_cnt_q}, 32'h0);
    sb.push_back(32'h15A);
    send(8'h5A, 8'hFF, "abort_next_miso");
    sb_check("abort_next_rx");

    // fill the buffer, then pop on the 8th sample edge
`ifdef CHU_SPI_SLV_RXFIFO_EN
    for (int i = 0; i < 4; i++) begin
      b = 8'h61 + 8'(i);
      sb.push_back({23'b0, 1'b1, b});
      send(b, 8'hFF, "fill_miso");
    end
`else
    sb.push_back(32'h166);
    send(8'h66, 8'hFF, "fill_miso");
`endif
    sb.push_back(32'h199);
    xfer(8'h99, 8, 1'b1, r, p);
    d = 'x;
    if (sb.size() != 0) d = sb.pop_front();
    check("sync_pop", p, d);
`ifdef CHU_SPI_SLV_RXFIFO_EN
    bus_rd(5'd2, d); check("sync_stat", d, 32'h43);
`else
    bus_rd(5'd2, d); check("sync_stat", d, 32'h13);
`endif
    while (sb.size() != 0) sb_check("sync_drain");

    // reset mid-byte in mode 2
    bus_wr(5'd3, 32'h1);
    spi_sclk = 1'b1;
    bus_wr(5'd1, 32'h77);
    repeat (4) @(negedge clk);
    spi_ss_n = 1'b0; spi_mosi = 1'b1;
    repeat (H) @(negedge clk);
    spi_sclk = 1'b0;
    repeat (H) @(negedge clk);
    spi_sclk = 1'b1;
    repeat (H) @(negedge clk);
    spi_sclk = 1'b0;
    repeat (3) @(negedge clk);
    bus_rd(5'd2, d); check("mid_busy", d, 32'hA);
    check("mid_miso", {31'b0, spi_miso}, 32'h1);
    reset = 1'b1;
    #1 check("rstm_miso", {31'b0, spi_miso}, 32'h0);
    @(negedge clk);
    bus_rd(5'd2, d); check("rstm_stat", d, 32'h2);
    bus_rd(5'd3, d); check("rstm_mode", d, 32'h0);
    bus_rd(5'd0, d); check("rstm_rx", d, 32'h0);
    spi_ss_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    bus_rd(5'd2, d); check("rstm_idle", d, 32'h2);
    cpol_m = 1'b0; cpha_m = 1'b0;
    sb.push_back(32'h1C3);
    send(8'hC3, 8'hFF, "rstm_next_miso");
    sb_check("rstm_next_rx");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
